enc8b10b_serializer: RTL and testbench

Parametrised 8b/10b encoder and serializer. It replaces the single-byte Serializer with proper running-disparity (RD) tracking, control (K) character support and a valid/ready word handshake, all on a single clock domain. A word of NUM_BYTES bytes is accepted, each byte is encoded to one 10-bit symbol, and symbols are shifted out one bit per clock with no gaps between back-to-back words. The output feeds the serial link/PHY model; the Deserializer path is the consumer.

---
 rtl/enc8b10b_serializer.sv | 224 ++++++++++++++++++++++
 tb/tb_enc8b10b_serializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/enc8b10b_serializer.sv
// 8b/10b encoder with running-disparity tracking, K-character support and a gapless
// bit serializer. Define SER_IDLE_COMMA_EN to fill idle time with K28.5 commas.
module enc8b10b_serializer #(
    parameter int unsigned NUM_BYTES = 2,
    parameter bit          A_FIRST   = 1'b1
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic [8*NUM_BYTES-1:0] i_Data,
    input  logic [NUM_BYTES-1:0]   i_K,
    input  logic                   i_Valid,
    output logic                   o_Ready,
    output logic                   o_Ser_Data,
    output logic                   o_Ser_Valid,
    output logic                   o_RD,
    output logic                   o_Code_Err
);

    localparam int unsigned     IDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [7:0]      COMMA    = 8'hBC;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                   state_q, state_d;
    logic [9:0]               sh_q, sh_d;
    logic [3:0]               bit_q, bit_d;
    logic [IDX_W-1:0]         byte_q, byte_d;
    logic [8*NUM_BYTES-1:0]   data_q, data_d;
    logic [NUM_BYTES-1:0]     k_q, k_d;
    logic                     rd_q, rd_d;
    logic                     err_q, err_d;
    logic                     valid_q, valid_d;
    logic                     ready_q, ready_d;

    logic                     accept, do_load, take_word, ld_k;
    logic [7:0]               ld_byte;
    logic [11:0]              enc;

    // 5b/6b code for RD- (abcdei, a in bit 5)
    function automatic logic [5:0] tbl6(input logic [4:0] x);
        case (x)
            5'd0:  return 6'b100111;  5'd1:  return 6'b011101;
            5'd2:  return 6'b101101;  5'd3:  return 6'b110001;
            5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
            5'd6:  return 6'b011001;  5'd7:  return 6'b111000;
            5'd8:  return 6'b111001;  5'd9:  return 6'b100101;
            5'd10: return 6'b010101;  5'd11: return 6'b110100;
            5'd12: return 6'b001101;  5'd13: return 6'b101100;
            5'd14: return 6'b011100;  5'd15: return 6'b010111;
            5'd16: return 6'b011011;  5'd17: return 6'b100011;
            5'd18: return 6'b010011;  5'd19: return 6'b110010;
            5'd20: return 6'b001011;  5'd21: return 6'b101010;
            5'd22: return 6'b011010;  5'd23: return 6'b111010;
            5'd24: return 6'b110011;  5'd25: return 6'b100110;
            5'd26: return 6'b010110;  5'd27: return 6'b110110;
            5'd28: return 6'b001110;  5'd29: return 6'b101110;
            5'd30: return 6'b011110;  default: return 6'b101011;
        endcase
    endfunction

    // 3b/4b code for RD- (fghj); data and control tables differ
    function automatic logic [3:0] tbl4(input logic [2:0] y, input logic k);
        case (y)
            3'd0:    return 4'b1011;
            3'd1:    return k ? 4'b0110 : 4'b1001;
            3'd2:    return k ? 4'b1010 : 4'b0101;
            3'd3:    return 4'b1100;
            3'd4:    return 4'b1101;
            3'd5:    return k ? 4'b0101 : 4'b1010;
            3'd6:    return k ? 4'b1001 : 4'b0110;
            default: return k ? 4'b0111 : 4'b1110;
        endcase
    endfunction

    // Returns {code_err, rd_out, abcdei, fghj}
    function automatic logic [11:0] encode(input logic [7:0] d, input logic k, input logic rd);
        logic       legal, err, rd6, alt7;
        logic [7:0] dd;
        logic [5:0] c6;
        logic [3:0] c4;
        legal = (d[4:0] == 5'd28) || (d == 8'hF7) || (d == 8'hFB) || (d == 8'hFD) || (d == 8'hFE);
        err   = k && !legal;
        dd    = err ? COMMA : d;
        c6    = (k && dd[4:0] == 5'd28) ? 6'b001111 : tbl6(dd[4:0]);
        // D.7 is balanced but still has distinct RD-/RD+ forms
        if (rd && (($countones(c6) != 3) || (!k && dd[4:0] == 5'd7)))
            c6 = ~c6;
        rd6 = rd ^ ($countones(c6) != 3);
        if (k) begin
            c4 = tbl4(dd[7:5], 1'b1);
            if (rd6)
                c4 = ~c4;
        end else begin
            alt7 = rd6 ? (dd[4:0] == 5'd11 || dd[4:0] == 5'd13 || dd[4:0] == 5'd14)
                       : (dd[4:0] == 5'd17 || dd[4:0] == 5'd18 || dd[4:0] == 5'd20);
            c4 = (dd[7:5] == 3'd7 && alt7) ? 4'b0111 : tbl4(dd[7:5], 1'b0);
            if (rd6 && (($countones(c4) != 2) || dd[7:5] == 3'd3))
                c4 = ~c4;
        end
        return {err, rd6 ^ ($countones(c4) != 2), c6, c4};
    endfunction

    function automatic logic [9:0] orient(input logic [9:0] c);
        logic [9:0] r;
        for (int n = 0; n < 10; n++)
            r[n] = c[9-n];
        return A_FIRST ? c : r;
    endfunction

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            data_q  <= '0;
            k_q     <= '0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            k_q     <= k_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = {sh_q[8:0], 1'b0};
        bit_d     = bit_q + 4'd1;
        byte_d    = byte_q;
        data_d    = data_q;
        k_d       = k_q;
        rd_d      = rd_q;
        err_d     = 1'b0;
        valid_d   = valid_q;
        do_load   = 1'b0;
        take_word = 1'b0;
        ld_byte   = COMMA;
        ld_k      = 1'b1;
        accept    = i_Valid && ready_q;

        case (state_q)
            IDLE: begin
`ifdef SER_IDLE_COMMA_EN
                do_load = 1'b1;
                byte_d  = LAST_IDX;
                state_d = SHIFT;
`else
                if (accept) begin
                    take_word = 1'b1;
                end else begin
                    sh_d    = '0;
                    bit_d   = '0;
                    valid_d = 1'b0;
                end
`endif
            end
            SHIFT: begin
                if (bit_q == 4'd9) begin
                    if (byte_q != LAST_IDX) begin
                        byte_d  = IDX_W'(byte_q + 1'b1);
                        do_load = 1'b1;
                        ld_byte = data_q[8*byte_d +: 8];
                        ld_k    = k_q[byte_d];
                    end else if (accept) begin
                        take_word = 1'b1;
                    end else begin
`ifdef SER_IDLE_COMMA_EN
                        do_load = 1'b1;
`else
                        state_d = IDLE;
                        sh_d    = '0;
                        bit_d   = '0;
                        valid_d = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_word) begin
            do_load = 1'b1;
            state_d = SHIFT;
            byte_d  = '0;
            data_d  = i_Data;
            k_d     = i_K;
            ld_byte = i_Data[7:0];
            ld_k    = i_K[0];
        end

        enc = encode(ld_byte, ld_k, rd_q);
        if (do_load) begin
            sh_d    = orient(enc[9:0]);
            rd_d    = enc[10];
            err_d   = enc[11];
            bit_d   = '0;
            valid_d = 1'b1;
        end

        ready_d = (state_d == SHIFT) && (bit_d == 4'd9) && (byte_d == LAST_IDX);
`ifndef SER_IDLE_COMMA_EN
        ready_d = ready_d || (state_d == IDLE);
`endif
    end

    assign o_Ready     = ready_q;
    assign o_Ser_Data  = sh_q[9];
    assign o_Ser_Valid = valid_q;
    assign o_RD        = rd_q;
    assign o_Code_Err  = err_q;

endmodule

// File: tb/tb_enc8b10b_serializer.sv
// Directed bench: a 1-byte instance runs a table of symbols back to back; a 2-byte
// instance covers gapless word handoff; plus reset-mid-symbol and reset-vs-accept.
module tb_enc8b10b_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  d1;
    logic        k1, v1, rdy1, sd1, sv1, rd1, ce1;
    logic [15:0] d2;
    logic [1:0]  k2;
    logic        v2, rdy2, sd2, sv2, rd2, ce2;

    int n_chk  = 0;
    int n_fail = 0;

    enc8b10b_serializer #(.NUM_BYTES(1), .A_FIRST(1'b1)) dut1 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Data(d1), .i_K(k1), .i_Valid(v1),
        .o_Ready(rdy1), .o_Ser_Data(sd1), .o_Ser_Valid(sv1), .o_RD(rd1), .o_Code_Err(ce1)
    );

    enc8b10b_serializer #(.NUM_BYTES(2), .A_FIRST(1'b1)) dut2 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Data(d2), .i_K(k2), .i_Valid(v2),
        .o_Ready(rdy2), .o_Ser_Data(sd2), .o_Ser_Valid(sv2), .o_RD(rd2), .o_Code_Err(ce2)
    );

    typedef struct {
        logic [7:0] data;
        logic       k;
        logic [9:0] sym;   // first transmitted bit on the left
        logic       rd;
        logic       err;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_rdy(input bit which);
        int t;
        t = 0;
        @(negedge clk);
        while (((which ? rdy2 : rdy1) !== 1'b1) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(which ? "ready2_wait" : "ready1_wait", 32'(which ? rdy2 : rdy1), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [9:0] sym;
        int         vbad, rbad, rcnt;
        logic       rd_s, err_s, err_later;
        logic [9:0] exp2[4];
        logic       exp2_rd[4];

        vecs[0]  = '{8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0};  // D.0.0
        vecs[1]  = '{8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0};  // K28.5 RD-
        vecs[2]  = '{8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0};  // K28.5 RD+
        vecs[3]  = '{8'hF1, 1'b0, 10'b1000110111, 1'b1, 1'b0};  // D.17.7 A7
        vecs[4]  = '{8'h00, 1'b1, 10'b1100000101, 1'b0, 1'b1};  // illegal K -> K28.5
        vecs[5]  = '{8'hB5, 1'b0, 10'b1010101010, 1'b0, 1'b0};  // D.21.5
        vecs[6]  = '{8'hEB, 1'b0, 10'b1101001110, 1'b1, 1'b0};  // D.11.7 RD- P7
        vecs[7]  = '{8'hEB, 1'b0, 10'b1101001000, 1'b0, 1'b0};  // D.11.7 RD+ A7
        vecs[8]  = '{8'hFC, 1'b1, 10'b0011111000, 1'b0, 1'b0};  // K28.7
        vecs[9]  = '{8'hF7, 1'b1, 10'b1110101000, 1'b0, 1'b0};  // K23.7
        vecs[10] = '{8'h63, 1'b0, 10'b1100011100, 1'b0, 1'b0};  // D.3.3
        vecs[11] = '{8'h07, 1'b0, 10'b1110001011, 1'b1, 1'b0};  // D.7.0 RD-
        vecs[12] = '{8'h07, 1'b0, 10'b0001110100, 1'b0, 1'b0};  // D.7.0 RD+
        vecs[13] = '{8'h3F, 1'b0, 10'b1010111001, 1'b1, 1'b0};  // D.31.1
        vecs[14] = '{8'h8F, 1'b0, 10'b1010001101, 1'b1, 1'b0};  // D.15.4 RD+
        vecs[15] = '{8'h3C, 1'b1, 10'b1100000110, 1'b0, 1'b0};  // K28.1 RD+

        exp2[0] = 10'b1001110100; exp2_rd[0] = 1'b0;  // D.0.0
        exp2[1] = 10'b1010101010; exp2_rd[1] = 1'b0;  // D.21.5
        exp2[2] = 10'b1000110111; exp2_rd[2] = 1'b1;  // D.17.7
        exp2[3] = 10'b1100000101; exp2_rd[3] = 1'b0;  // K28.5 RD+

        rst_n = 1'b0;
        d1 = '0; k1 = 1'b0; v1 = 1'b0;
        d2 = '0; k2 = '0;   v2 = 1'b0;
        rd_s = 1'b0; err_s = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dut1", 32'({rdy1, sd1, sv1, rd1, ce1}), 32'd0);
        check("reset_dut2", 32'({rdy2, sd2, sv2, rd2, ce2}), 32'd0);
        rst_n = 1'b1;

        // Table: symbols streamed back to back through the 1-byte instance
        wait_rdy(1'b0);
        d1 = vecs[0].data; k1 = vecs[0].k; v1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            sym = '0; vbad = 0; rbad = 0; err_later = 1'b0;
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                sym = {sym[8:0], sd1};
                if (sv1 !== 1'b1) vbad++;
                if (rdy1 !== (j == 9)) rbad++;
                if (j == 0) begin
                    rd_s  = rd1;
                    err_s = ce1;
                end else if (ce1 !== 1'b0) begin
                    err_later = 1'b1;
                end
                if (j == 9) begin
                    if (i < 15) begin
                        d1 = vecs[i+1].data; k1 = vecs[i+1].k;
                    end else begin
                        v1 = 1'b0;
                    end
                end
            end
            check($sformatf("sym[%0d]", i), 32'(sym), 32'(vecs[i].sym));
            check($sformatf("rd[%0d]", i), 32'(rd_s), 32'(vecs[i].rd));
            check($sformatf("err[%0d]", i), 32'({err_s, err_later}), 32'({vecs[i].err, 1'b0}));
            check($sformatf("valid_bits[%0d]", i), 32'(vbad), 32'd0);
            check($sformatf("ready_bits[%0d]", i), 32'(rbad), 32'd0);
        end
        @(negedge clk);
        check("idle_after_table", 32'({rdy1, sv1, sd1}), 32'b100);

        // Reset after 5 bits of a symbol that left RD+
        d1 = 8'hF1; k1 = 1'b0; v1 = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            v1 = 1'b0;
            if (j == 0) check("rd_before_reset", 32'(rd1), 32'd1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_symbol", 32'({rdy1, sd1, sv1, rd1, ce1}), 32'd0);
        rst_n = 1'b1;
        wait_rdy(1'b0);
        d1 = 8'h00; k1 = 1'b0; v1 = 1'b1;
        @(posedge clk);
        sym = '0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            v1 = 1'b0;
            sym = {sym[8:0], sd1};
            if (j == 0) rd_s = rd1;
        end
        check("sym_after_reset", 32'(sym), 32'(10'b1001110100));
        check("rd_after_reset", 32'(rd_s), 32'd0);

        // Two-byte words handed over gaplessly on the ready cycle
        wait_rdy(1'b1);
        d2 = 16'hB5_00; k2 = 2'b00; v2 = 1'b1;
        @(posedge clk);
        sym = '0; vbad = 0; rbad = 0; rcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0)  begin d2 = 16'hFFFF; k2 = 2'b11; end
            if (c == 20) begin v2 = 1'b0; d2 = 16'h1234; k2 = 2'b11; end
            sym = {sym[8:0], sd2};
            if (sv2 !== 1'b1) vbad++;
            if (rdy2 === 1'b1) rcnt++;
            if (rdy2 !== (c == 19 || c == 39)) rbad++;
            if (c % 10 == 0)
                check($sformatf("w_rd[%0d]", c / 10), 32'(rd2), 32'(exp2_rd[c / 10]));
            if (c % 10 == 9)
                check($sformatf("w_sym[%0d]", c / 10), 32'(sym), 32'(exp2[c / 10]));
            if (c == 19) begin
                d2 = 16'hBC_F1; k2 = 2'b10; v2 = 1'b1;
            end
        end
        check("w_valid_contig", 32'(vbad), 32'd0);
        check("w_ready_count", 32'(rcnt), 32'd2);
        check("w_ready_pos", 32'(rbad), 32'd0);
        @(negedge clk);
        check("w_idle", 32'({rdy2, sv2, sd2}), 32'b100);

        // Reset and accept on the same edge: reset wins
        d2 = 16'h0000; k2 = 2'b00; v2 = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        check("rst_vs_accept", 32'({rdy2, sv2, rd2}), 32'd0);
        v2 = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("rst_vs_accept_idle", 32'({rdy2, sv2}), 32'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
